// File: rtl/wdata_ser.sv
// Multi-channel serial DAC writer: latches one word per channel on start and
// shifts all channels out in lockstep under an active-low frame select.
module wdata_ser #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CH_N   = 2,
    parameter int unsigned GAP    = 1,
    parameter int unsigned AW     = $clog2(DATA_W)
) (
    input  logic                   clk_cs,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   lsb_first,
    input  logic                   abort,
    input  logic [CH_N*DATA_W-1:0] din,
    output logic                   ready,
    output logic                   busy,
    output logic                   dcs_n,
    output logic [CH_N-1:0]        dacs,
    output logic [AW-1:0]          waddr,
    output logic                   done
);

    localparam logic [AW-1:0] LAST = AW'(DATA_W - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] sh [CH_N];
    logic              lsb_q;
    logic [AW-1:0]     cnt;
    logic [3:0]        gap_cnt;
    logic [CH_N-1:0]   dacs_nx;

    always_comb begin
        state_nx = state;
        ready    = (state == ST_IDLE);
        unique case (state)
            ST_IDLE:  if (start && !abort) state_nx = ST_SHIFT;
            ST_SHIFT: begin
                if (abort)
                    state_nx = ST_IDLE;
                else if (cnt == LAST)
                    state_nx = (GAP != 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP:   if (abort || gap_cnt == 4'd0) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        dacs_nx = '0;
        for (int unsigned c = 0; c < CH_N; c++)
            dacs_nx[c] = lsb_q ? sh[c][0] : sh[c][DATA_W-1];
    end

    always_ff @(posedge clk_cs or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // The FSM runs one cycle ahead of the output registers, so the last bit is
    // still on the wire while the FSM is already in IDLE and may accept again.
    always_ff @(posedge clk_cs or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < CH_N; c++)
                sh[c] <= '0;
            lsb_q   <= 1'b0;
            cnt     <= '0;
            gap_cnt <= '0;
            dcs_n   <= 1'b1;
            dacs    <= '0;
            waddr   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (state == ST_IDLE && state_nx == ST_SHIFT) begin
                for (int unsigned c = 0; c < CH_N; c++)
                    sh[c] <= din[c*DATA_W +: DATA_W];
                lsb_q <= lsb_first;
                cnt   <= '0;
            end else if (state == ST_SHIFT) begin
                for (int unsigned c = 0; c < CH_N; c++)
                    sh[c] <= lsb_q ? (sh[c] >> 1) : (sh[c] << 1);
                cnt <= (cnt == LAST) ? '0 : cnt + AW'(1);
            end

            if (state == ST_SHIFT && state_nx == ST_GAP)
                gap_cnt <= 4'(GAP - 1);
            else if (state == ST_GAP && gap_cnt != 4'd0)
                gap_cnt <= gap_cnt - 4'd1;

            done <= !abort && !dcs_n && (waddr == LAST);
            busy <= !abort && (state_nx != ST_IDLE || state == ST_SHIFT);

            if (!abort && state == ST_SHIFT) begin
                dcs_n <= 1'b0;
                dacs  <= dacs_nx;
                waddr <= cnt;
            end else begin
                dcs_n <= 1'b1;
                dacs  <= '0;
                waddr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wdata_ser.sv
// Bench for wdata_ser: an 8-bit/2-channel/no-gap instance and a
// 5-bit/3-channel/gap-3 instance, checked against a per-cycle frame model.
module tb_wdata_ser;

    logic        clk_cs, rst;
    logic        start, lsb_first, abort;
    logic [15:0] din;
    logic        ready, busy, dcs_n, done;
    logic [1:0]  dacs;
    logic [2:0]  waddr;

    logic        start2, lsb2, abort2;
    logic [14:0] din2;
    logic        ready2, busy2, dcs2_n, done2;
    logic [2:0]  dacs2;
    logic [2:0]  waddr2;

    int n_pass  = 0;
    int n_total = 0;

    wdata_ser #(.DATA_W(8), .CH_N(2), .GAP(0)) dut (
        .clk_cs(clk_cs), .rst(rst), .start(start), .lsb_first(lsb_first),
        .abort(abort), .din(din), .ready(ready), .busy(busy), .dcs_n(dcs_n),
        .dacs(dacs), .waddr(waddr), .done(done)
    );

    wdata_ser #(.DATA_W(5), .CH_N(3), .GAP(3)) dut2 (
        .clk_cs(clk_cs), .rst(rst), .start(start2), .lsb_first(lsb2),
        .abort(abort2), .din(din2), .ready(ready2), .busy(busy2), .dcs_n(dcs2_n),
        .dacs(dacs2), .waddr(waddr2), .done(done2)
    );

    initial clk_cs = 1'b0;
    always #5 clk_cs = ~clk_cs;

    // Bit i of a frame: channel word bit (W-1-i) in MSB mode, bit i in LSB mode.
    function automatic logic [1:0] m1_bits(input logic [15:0] d, input logic lsb, input int i);
        logic [1:0] r;
        int idx;
        idx = lsb ? i : 7 - i;
        for (int c = 0; c < 2; c++) r[c] = d[c*8 + idx];
        return r;
    endfunction

    function automatic logic [2:0] m2_bits(input logic [14:0] d, input logic lsb, input int i);
        logic [2:0] r;
        int idx;
        idx = lsb ? i : 4 - i;
        for (int c = 0; c < 3; c++) r[c] = d[c*5 + idx];
        return r;
    endfunction

    task automatic frame_main(input logic [15:0] d, input logic lsb, input string tag);
        logic [7:0] obs, exp;
        for (int n = 0; n < 40 && ready !== 1'b1; n++) @(negedge clk_cs);
        n_total++;
        if (ready !== 1'b1) $display("FAIL %s ready_wait: got %b want 1", tag, ready);
        else n_pass++;
        start = 1'b1; din = d; lsb_first = lsb;
        @(negedge clk_cs);
        n_total++;
        if ({dcs_n, ready} !== 2'b10) $display("FAIL %s accept: got {dcs_n,ready}=%b want 10", tag, {dcs_n, ready});
        else n_pass++;
        start = 1'b0; din = 16'($urandom); lsb_first = ~lsb;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_cs);
            obs = {dcs_n, done, busy, waddr, dacs};
            exp = {1'b0, 1'b0, 1'b1, 3'(i), m1_bits(d, lsb, i)};
            n_total++;
            if (obs !== exp) $display("FAIL %s bit%0d: got %b want %b", tag, i, obs, exp);
            else n_pass++;
        end
        @(negedge clk_cs);
        n_total++;
        if ({dcs_n, done, dacs} !== 4'b1100) $display("FAIL %s end: got {dcs_n,done,dacs}=%b want 1100", tag, {dcs_n, done, dacs});
        else n_pass++;
        @(negedge clk_cs);
        n_total++;
        if ({done, ready} !== 2'b01) $display("FAIL %s post: got {done,ready}=%b want 01", tag, {done, ready});
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b1; din = 16'h1234; lsb_first = 1'b0; abort = 1'b0;
        start2 = 1'b0; lsb2 = 1'b0; abort2 = 1'b0; din2 = '0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk_cs);
            n_total++;
            if ({dcs_n, dacs, waddr, busy, done, ready} !== 9'b1_00_000_001)
                $display("FAIL reset%0d: got %b want 100000001", n, {dcs_n, dacs, waddr, busy, done, ready});
            else n_pass++;
        end
        n_total++;
        if ({dcs2_n, dacs2, waddr2, busy2, done2, ready2} !== 10'b1_000_000_001)
            $display("FAIL reset2: got %b want 1000000001", {dcs2_n, dacs2, waddr2, busy2, done2, ready2});
        else n_pass++;
        rst = 1'b1;
        @(negedge clk_cs);
        n_total++;
        if ({dcs_n, ready} !== 2'b10) $display("FAIL reset_accept: got {dcs_n,ready}=%b want 10", {dcs_n, ready});
        else n_pass++;
        start = 1'b0;
        @(negedge clk_cs);
        n_total++;
        if (dcs_n !== 1'b0) $display("FAIL reset_first_bit: got dcs_n=%b want 0", dcs_n);
        else n_pass++;
        repeat (9) @(negedge clk_cs);
        n_total++;
        if (ready !== 1'b1) $display("FAIL reset_frame_end: got ready=%b want 1", ready);
        else n_pass++;
    endtask

    task automatic test_msb;
        frame_main(16'h3CA5, 1'b0, "msb");
    endtask

    task automatic test_lsb;
        frame_main(16'h3CA5, 1'b1, "lsb");
    endtask

    task automatic test_random;
        for (int n = 0; n < 6; n++) frame_main(16'($urandom), 1'($urandom), "rand");
    endtask

    task automatic test_back_to_back;
        logic [15:0] d [3];
        logic        l [3];
        logic [6:0]  obs, exp;
        int u, f;
        for (int n = 0; n < 3; n++) begin d[n] = 16'($urandom); l[n] = 1'($urandom); end
        for (int n = 0; n < 40 && ready !== 1'b1; n++) @(negedge clk_cs);
        start = 1'b1; din = d[0]; lsb_first = l[0];
        for (int t = 0; t < 28; t++) begin
            @(negedge clk_cs);
            u = t % 9; f = t / 9;
            obs = {dcs_n, done, waddr, dacs};
            if (u == 0) exp = {1'b1, (t > 0), 3'd0, 2'd0};
            else        exp = {1'b0, 1'b0, 3'(u - 1), m1_bits(d[f], l[f], u - 1)};
            n_total++;
            if (obs !== exp) $display("FAIL b2b t%0d: got %b want %b", t, obs, exp);
            else n_pass++;
            if (t == 0) begin din = d[1]; lsb_first = l[1]; end
            if (t == 9) begin din = d[2]; lsb_first = l[2]; end
            if (t == 18) begin start = 1'b0; din = 16'($urandom); end
        end
        @(negedge clk_cs);
    endtask

    task automatic test_abort;
        for (int n = 0; n < 40 && ready !== 1'b1; n++) @(negedge clk_cs);
        start = 1'b1; din = 16'($urandom); lsb_first = 1'b0;
        @(negedge clk_cs);
        start = 1'b0;
        repeat (4) @(negedge clk_cs);
        n_total++;
        if (waddr !== 3'd3) $display("FAIL abort_pos: got waddr=%0d want 3", waddr);
        else n_pass++;
        abort = 1'b1;
        @(negedge clk_cs);
        n_total++;
        if ({dcs_n, dacs, busy, ready, done, waddr} !== 9'b1_00_0_1_0_000)
            $display("FAIL abort_edge: got %b want 100010000", {dcs_n, dacs, busy, ready, done, waddr});
        else n_pass++;
        abort = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk_cs);
            n_total++;
            if ({dcs_n, done} !== 2'b10) $display("FAIL abort_quiet%0d: got {dcs_n,done}=%b want 10", n, {dcs_n, done});
            else n_pass++;
        end
        start = 1'b1; abort = 1'b1;
        @(negedge clk_cs);
        n_total++;
        if ({ready, dcs_n} !== 2'b11) $display("FAIL abort_wins: got {ready,dcs_n}=%b want 11", {ready, dcs_n});
        else n_pass++;
        start = 1'b0; abort = 1'b0;
        @(negedge clk_cs);
        n_total++;
        if ({dcs_n, busy} !== 2'b10) $display("FAIL abort_no_frame: got {dcs_n,busy}=%b want 10", {dcs_n, busy});
        else n_pass++;
        frame_main(16'($urandom), 1'($urandom), "post_abort");
    endtask

    task automatic test_gap;
        logic [14:0] d [3];
        logic        l [3];
        logic [8:0]  obs, exp;
        int u, f;
        for (int n = 0; n < 3; n++) begin d[n] = 15'($urandom); l[n] = 1'($urandom); end
        for (int n = 0; n < 40 && ready2 !== 1'b1; n++) @(negedge clk_cs);
        start2 = 1'b1; din2 = d[0]; lsb2 = l[0];
        for (int t = 0; t < 29; t++) begin
            @(negedge clk_cs);
            u = t % 9; f = t / 9;
            obs = {dcs2_n, done2, ready2, waddr2, dacs2};
            if (f > 2)                exp = {1'b1, 1'b0, 1'b1, 3'd0, 3'd0};
            else if (u >= 1 && u <= 5) exp = {1'b0, 1'b0, 1'b0, 3'(u - 1), m2_bits(d[f], l[f], u - 1)};
            else                      exp = {1'b1, (u == 6), (u == 8), 3'd0, 3'd0};
            n_total++;
            if (obs !== exp) $display("FAIL gap t%0d: got %b want %b", t, obs, exp);
            else n_pass++;
            if (t == 0)  begin din2 = d[1]; lsb2 = l[1]; end
            if (t == 9)  begin start2 = 1'b0; din2 = 15'($urandom); end
            if (t == 17) begin start2 = 1'b1; din2 = d[2]; lsb2 = l[2]; end
            if (t == 18) begin start2 = 1'b0; din2 = 15'($urandom); lsb2 = 1'($urandom); end
            if (t == 24) start2 = 1'b1;
            if (t == 25) start2 = 1'b0;
        end
    endtask

    task automatic test_async_reset;
        for (int n = 0; n < 40 && ready !== 1'b1; n++) @(negedge clk_cs);
        start = 1'b1; din = 16'($urandom); lsb_first = 1'($urandom);
        @(negedge clk_cs);
        start = 1'b0;
        repeat (6) @(negedge clk_cs);
        n_total++;
        if (waddr !== 3'd5) $display("FAIL arst_pos: got waddr=%0d want 5", waddr);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if ({dcs_n, dacs, waddr, busy} !== 7'b1_00_000_0)
            $display("FAIL arst_immediate: got %b want 1000000", {dcs_n, dacs, waddr, busy});
        else n_pass++;
        @(negedge clk_cs);
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk_cs);
            n_total++;
            if ({dcs_n, done, ready} !== 3'b101) $display("FAIL arst_after%0d: got {dcs_n,done,ready}=%b want 101", n, {dcs_n, done, ready});
            else n_pass++;
        end
        frame_main(16'($urandom), 1'($urandom), "post_arst");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_msb;
        test_lsb;
        test_random;
        test_back_to_back;
        test_abort;
        test_gap;
        test_async_reset;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
